toggle_bank_arbiter: RTL and testbench

- Controller and arbiter for a shared bank of level-sensitive T storage cells.
- N requesters each ask to toggle a set of bits in the bank.
- The block grants requesters round-robin, drives the bank's T inputs and level enable with a safe setup/pulse/guard sequence, and keeps a shadow copy of the bank state.
- Sits between requester logic and the T-cell bank; it is the only driver of the bank's T/enable pins.

---
 rtl/toggle_bank_arbiter_if.sv | 33 +++
 rtl/toggle_bank_arbiter.sv | 120 ++++++++++++
 tb/tb_toggle_bank_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_bank_arbiter_if.sv
// Requester/bank-side bundle for toggle_bank_arbiter.
//   req      : per-requester request level
//   mask     : per-requester toggle mask, slice i = mask[i*W +: W]
//   ack      : one-cycle completion pulse to the granted requester
//   gnt      : one-hot grant, high from grant until ack inclusive
//   busy     : controller not idle
//   t_data   : T inputs to the bank
//   t_en     : level enable (C) to the bank
//   q_shadow : shadow copy of the bank state
// master = requester/bench side, slave = arbiter side.
interface toggle_bank_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] mask;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   t_data;
    logic           t_en;
    logic [W-1:0]   q_shadow;

    modport master (
        output req, mask,
        input  ack, gnt, busy, t_data, t_en, q_shadow
    );

    modport slave (
        input  req, mask,
        output ack, gnt, busy, t_data, t_en, q_shadow
    );
endinterface

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter and sequencer for a bank of level-sensitive T cells.
// Each grant drives the bank with a setup / pulse(HOLD) / guard sequence so the
// enable is only high while t_data is stable, then acks the requester.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : toggle_bank_arbiter_if.slave (req/mask in; ack/gnt/busy/t_data/t_en/q_shadow out)
module toggle_bank_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    toggle_bank_arbiter_if.slave  bus
);
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [N-1:0] OneHot0 = N'(1);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StGuard, StAck} state_e;

    state_e          state_q;
    logic [IdxW-1:0] ptr_q;
    logic [W-1:0]    mask_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]    ack_q;
    logic [N-1:0]    gnt_q;
    logic [W-1:0]    t_data_q;
    logic            t_en_q;
    logic [W-1:0]    shadow_q;

    // Winner search: first set req bit at or after ptr_q, wrapping modulo N.
    logic            found;
    logic [IdxW-1:0] win;
    logic [W-1:0]    win_mask;
    int unsigned     cand;

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = IdxW'(cand);
            end
        end
        win_mask = bus.mask[win*W +: W];
    end

    // All outputs are registered: each is set on the transition into the
    // state in which it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            gnt_q    <= '0;
            t_data_q <= '0;
            t_en_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_q <= '0;
                    if (found) begin
                        gnt_q  <= OneHot0 << win;
                        mask_q <= win_mask;
                        ptr_q  <= (win == IdxW'(N - 1)) ? '0 : win + 1'b1;
                        if (win_mask == '0) begin
                            // Nothing to toggle: skip the bank sequence.
                            ack_q   <= OneHot0 << win;
                            state_q <= StAck;
                        end else begin
                            t_data_q <= win_mask;
                            state_q  <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    t_en_q  <= 1'b1;
                    cnt_q   <= CntW'(HOLD - 1);
                    state_q <= StPulse;
                end
                StPulse: begin
                    if (cnt_q == '0) begin
                        // Enable falls while t_data still holds the mask.
                        t_en_q   <= 1'b0;
                        shadow_q <= shadow_q ^ mask_q;
                        state_q  <= StGuard;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StGuard: begin
                    t_data_q <= '0;
                    ack_q    <= gnt_q;
                    state_q  <= StAck;
                end
                StAck: begin
                    ack_q   <= '0;
                    gnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.gnt      = gnt_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.t_data   = t_data_q;
    assign bus.t_en     = t_en_q;
    assign bus.q_shadow = shadow_q;
endmodule

// File: tb/tb_toggle_bank_arbiter.sv
module tb_toggle_bank_arbiter;
    localparam int unsigned N    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    toggle_bank_arbiter_if #(.N(N), .W(W)) bus ();

    toggle_bank_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Per-cycle invariants: gnt one-hot or zero, ack within gnt, t_en only while busy.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (!$onehot0(bus.gnt) || ((bus.ack & ~bus.gnt) != '0) || (bus.t_en && !bus.busy)) begin
                n_fail++;
                $display("FAIL invariant: gnt=%b ack=%b t_en=%b busy=%b", bus.gnt, bus.ack,
                         bus.t_en, bus.busy);
            end
        end
    end

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Step until ack is nonzero, bounded; reports whether it arrived.
    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req  = '0;
        bus.mask = '0;
        do_reset();
        n_checks++;
        if ({bus.gnt, bus.ack, bus.busy, bus.t_en, bus.t_data, bus.q_shadow} !== '0) begin
            n_fail++;
            $display("FAIL reset: gnt=%b ack=%b busy=%b t_en=%b t_data=%h q=%h required all 0",
                     bus.gnt, bus.ack, bus.busy, bus.t_en, bus.t_data, bus.q_shadow);
        end
    endtask

    task automatic test_single();
        bus.mask[0*W +: W] = 8'h0F;
        bus.req = 4'b0001;                     // cycle 0
        step();                                // cycle 1
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.t_en !== 1'b0 || bus.t_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL single_c1: gnt=%b busy=%b t_en=%b t_data=%h required 0001 1 0 0f",
                     bus.gnt, bus.busy, bus.t_en, bus.t_data);
        end
        for (int c = 2; c <= 3; c++) begin
            step();
            n_checks++;
            if (bus.t_en !== 1'b1 || bus.t_data !== 8'h0F) begin
                n_fail++;
                $display("FAIL single_pulse c%0d: t_en=%b t_data=%h required 1 0f", c, bus.t_en,
                         bus.t_data);
            end
        end
        step();                                // cycle 4
        n_checks++;
        if (bus.t_en !== 1'b0 || bus.t_data !== 8'h0F || bus.q_shadow !== 8'h0F || bus.ack !== '0) begin
            n_fail++;
            $display("FAIL single_guard: t_en=%b t_data=%h q=%h ack=%b required 0 0f 0f 0000",
                     bus.t_en, bus.t_data, bus.q_shadow, bus.ack);
        end
        step();                                // cycle 5
        n_checks++;
        if (bus.ack !== 4'b0001 || bus.t_data !== 8'h00 || bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b t_data=%h gnt=%b required 0001 00 0001", bus.ack,
                     bus.t_data, bus.gnt);
        end
        bus.req = '0;
        step();                                // cycle 6
        n_checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.ack !== '0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b gnt=%b ack=%b required 0 0000 0000", bus.busy,
                     bus.gnt, bus.ack);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] exp_q   [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
        int last_cyc = 0;
        bit ok;
        do_reset();
        bus.mask = {8'h08, 8'h04, 8'h02, 8'h01};
        bus.req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(ok);
            n_checks++;
            if (!ok || bus.ack !== exp_ack[k] || bus.q_shadow !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rr_ack%0d: ok=%0b ack=%b q=%h required %b %h", k, ok, bus.ack,
                         bus.q_shadow, exp_ack[k], exp_q[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (cyc - last_cyc != 6) begin
                    n_fail++;
                    $display("FAIL rr_spacing%0d: got %0d cycles required 6", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
        end
        bus.req = '0;
        step();
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        bus.req = 4'b1000;
        wait_ack(ok);
        bus.req = 4'b1001;
        step();                                // back in idle, samples req
        step();
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first: gnt=%b required 0001", bus.gnt);
        end
        wait_ack(ok);
        bus.req = 4'b1000;
        step();
        step();
        n_checks++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_second: gnt=%b required 1000", bus.gnt);
        end
        wait_ack(ok);
        bus.req = '0;
        step();
        n_checks++;
        if (!ok || bus.q_shadow !== 8'h0F) begin
            n_fail++;
            $display("FAIL wrap_shadow: ok=%0b q=%h required 1 0f", ok, bus.q_shadow);
        end
    endtask

    task automatic test_zero_mask();
        bus.mask[2*W +: W] = 8'h00;
        bus.req = 4'b0100;                     // cycle 0
        step();                                // cycle 1: grant goes straight to ack
        n_checks++;
        if (bus.gnt !== 4'b0100 || bus.ack !== 4'b0100 || bus.t_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_ack: gnt=%b ack=%b t_en=%b required 0100 0100 0", bus.gnt,
                     bus.ack, bus.t_en);
        end
        bus.req = '0;
        step();                                // cycle 2
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.t_en !== 1'b0 || bus.q_shadow !== 8'h0F) begin
            n_fail++;
            $display("FAIL zero_after: busy=%b ack=%b t_en=%b q=%h required 0 0000 0 0f",
                     bus.busy, bus.ack, bus.t_en, bus.q_shadow);
        end
    endtask

    task automatic test_mid_change();
        bit ok;
        bus.mask[1*W +: W] = 8'hAA;
        bus.req = 4'b0010;                     // cycle 0
        step();                                // cycle 1
        n_checks++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_gnt: gnt=%b required 0010", bus.gnt);
        end
        step();                                // cycle 2, PULSE
        bus.mask[1*W +: W] = 8'h55;
        bus.req = '0;
        for (int c = 3; c <= 4; c++) begin
            step();
            n_checks++;
            if (bus.t_data !== 8'hAA) begin
                n_fail++;
                $display("FAIL mid_data c%0d: t_data=%h required aa", c, bus.t_data);
            end
        end
        n_checks++;
        if (bus.q_shadow !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_shadow: q=%h required a5", bus.q_shadow);
        end
        wait_ack(ok);
        n_checks++;
        if (!ok || bus.ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_ack: ok=%0b ack=%b required 1 0010", ok, bus.ack);
        end
        step();
    endtask

    task automatic test_reset_in_pulse();
        bit ok;
        bus.mask[2*W +: W] = 8'h33;
        bus.req = 4'b0100;                     // cycle 0
        step();
        step();                                // cycle 2
        n_checks++;
        if (bus.t_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstp_pulse: t_en=%b required 1", bus.t_en);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.t_en !== 1'b0 || bus.gnt !== '0 || bus.ack !== '0 || bus.q_shadow !== 8'h00 ||
            bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstp_abort: t_en=%b gnt=%b ack=%b q=%h busy=%b required 0 0000 0000 00 0",
                     bus.t_en, bus.gnt, bus.ack, bus.q_shadow, bus.busy);
        end
        bus.req = 4'b1111;
        step();
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstp_ptr: gnt=%b required 0001", bus.gnt);
        end
        wait_ack(ok);
        bus.req = '0;
        n_checks++;
        if (!ok || bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstp_ack: ok=%0b ack=%b required 1 0001", ok, bus.ack);
        end
        step();
    endtask

    initial begin
        bus.req  = '0;
        bus.mask = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_zero_mask();
        test_mid_change();
        test_reset_in_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
